// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a parallel write port feeds an internal FIFO,
// and the FIFO head is serialised LSB-first at P_CLK_HZ/P_BAUD clocks per bit.
module uart_tx #(
    parameter int P_CLK_HZ          = 500000000,
    parameter int P_BAUD            = 9600,
    parameter int P_FIFO_DEPTH_LOG2 = 4
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic       serial_out,
    output logic       busy,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       error
);

    localparam int LP_DIV   = P_CLK_HZ / P_BAUD;
    localparam int LP_CNT_W = (LP_DIV > 1) ? $clog2(LP_DIV) : 1;
    localparam int LP_DEPTH = 1 << P_FIFO_DEPTH_LOG2;
    localparam int LP_PTR_W = P_FIFO_DEPTH_LOG2;
    localparam int LP_CNT_F = P_FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LP_CNT_W-1:0]   r_baud_cnt;
    logic [LP_CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]            r_bit_idx;
    logic [2:0]            w_idx_nxt;
    logic [7:0]            r_shift;
    logic [7:0]            w_shift_nxt;
    logic                  r_serial;
    logic                  r_busy;
    logic                  w_serial_nxt;
    logic                  w_busy_nxt;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_tick;
    logic [7:0]            w_head;

    logic [7:0]            r_mem [LP_DEPTH];
    logic [LP_PTR_W-1:0]   r_wr_ptr;
    logic [LP_PTR_W-1:0]   r_rd_ptr;
    logic [LP_CNT_F-1:0]   r_count;
    logic [LP_CNT_F-1:0]   w_count_nxt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_error;

    // Full is the registered (pre-edge) flag, so a write racing a pop at full is still refused.
    assign w_wr   = wr_en & ~r_full;
    assign w_tick = (r_baud_cnt == LP_CNT_W'(LP_DIV - 1));
    assign w_head = r_mem[r_rd_ptr];

    // Next-state logic: bit timing, bit index, shift register and FIFO pop requests.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_baud_cnt;
        w_idx_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_cnt_nxt = r_baud_cnt + LP_CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_baud_cnt + LP_CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_cnt_nxt = '0;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (!r_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_baud_cnt + LP_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Line and busy values derived from the upcoming state so both outputs can be registered.
    always_comb begin
        w_serial_nxt = 1'b1;
        w_busy_nxt   = 1'b1;
        case (w_state_nxt)
            ST_IDLE:  begin w_serial_nxt = 1'b1;           w_busy_nxt = 1'b0; end
            ST_START: begin w_serial_nxt = 1'b0;           w_busy_nxt = 1'b1; end
            ST_DATA:  begin w_serial_nxt = w_shift_nxt[0]; w_busy_nxt = 1'b1; end
            ST_STOP:  begin w_serial_nxt = 1'b1;           w_busy_nxt = 1'b1; end
            default:  begin w_serial_nxt = 1'b1;           w_busy_nxt = 1'b0; end
        endcase
    end

    // FIFO occupancy after this edge: a simultaneous write and pop leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + LP_CNT_F'(1);
            2'b01:   w_count_nxt = r_count - LP_CNT_F'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Transmit state, timing and registered line outputs.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_serial   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_cnt_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_serial   <= w_serial_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // FIFO pointers, occupancy flags and the sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_error  <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + LP_PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + LP_PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == LP_CNT_F'(LP_DEPTH));
            r_empty <= (w_count_nxt == LP_CNT_F'(0));
            if (wr_en && r_full) r_error <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge CLK) begin
        if (reset_n && w_wr) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    assign serial_out = r_serial;
    assign busy       = r_busy;
    assign fifo_full  = r_full;
    assign fifo_empty = r_empty;
    assign error      = r_error;

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered 8N1 UART transmitter and the transmit-side companion of `uart_rx`. Bytes written on a parallel strobe interface are queued in an internal FIFO, then serialised LSB-first on `serial_out` at a fixed baud rate derived from the system clock. It sits between on-board byte producers and the RS-232 line driver, and loops back directly into `uart_rx` for board test.

## Interface

- `P_CLK_HZ`, default 500000000: system clock frequency in Hz.
- `P_BAUD`, default 9600: line baud rate.
- `P_FIFO_DEPTH_LOG2`, default 4: FIFO depth is 2^P_FIFO_DEPTH_LOG2 entries (16).
- Derived: `LP_DIV = P_CLK_HZ / P_BAUD`, integer division (52083 at defaults); baud counter width is ceil(log2(LP_DIV)).

- `CLK` in 1: system clock; all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `data_in` in 8: byte to queue.
- `wr_en` in 1: write strobe, one byte per asserted cycle.
- `serial_out` out 1: UART line, idle high.
- `busy` out 1: high while a frame is on the line.
- `fifo_full` out 1: FIFO holds 2^P_FIFO_DEPTH_LOG2 entries.
- `fifo_empty` out 1: FIFO holds 0 entries.
- `error` out 1: sticky overflow flag, set when a write is attempted while full.

## Operation

- Frame format: 1 start bit (0), 8 data bits (LSB first), 1 stop bit (1). No parity.
- Every bit is held exactly `LP_DIV` cycles, so one frame is 10*`LP_DIV` cycles.
- The FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: `serial_out`=1 and `busy`=0. If the FIFO is not empty, pop the head into the shift register and go to START.
  - START: `serial_out`=0 for `LP_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `serial_out`=shift[0] for `LP_DIV` cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `serial_out`=1 for `LP_DIV` cycles. At the end, if the FIFO is not empty, pop and go directly to START, so consecutive frames have no idle gap. Otherwise go to IDLE.
- FIFO write:
  - On a rising edge with `wr_en`=1 and `fifo_full`=0 (pre-edge value), store `data_in`.
  - A write while full is dropped and sets `error`=1.
  - `error` clears only on reset.
- Simultaneous write and pop:
  - Both take effect and the count is unchanged.
  - When full, the write is still rejected because full is evaluated pre-edge. The count drops to depth-1 and `error` is set.
- Pointers wrap modulo depth. The count uses P_FIFO_DEPTH_LOG2+1 bits.
- `busy` is 1 in START, DATA and STOP.

## Timing

- Values during and after reset: `serial_out`=1, `busy`=0, `fifo_empty`=1, `fifo_full`=0, `error`=0, FSM in IDLE, FIFO pointers and count at 0.
- Write-to-line latency, empty FIFO and IDLE:
  - Edge N samples `wr_en`, and `fifo_empty` falls after edge N.
  - Edge N+1 pops the byte, and `serial_out` falls after edge N+1.
- `busy` rises on the same edge as the start bit and falls on the edge that ends the last stop bit when no further byte is pending.
- Flags `fifo_full` and `fifo_empty` are registered and reflect the count after each edge.
- Reset asserted mid-frame: on the next edge `serial_out` returns to 1, the frame is aborted, and FIFO contents are discarded.
- `data_in` is ignored when `wr_en`=0.

## Test plan

Scenarios 1–5 and 7 use `P_CLK_HZ`=100, `P_BAUD`=10, so `LP_DIV`=10.

1. **Reset/idle.** Hold `reset_n`=0 for 5 cycles, then release and idle 200 cycles. Required: `serial_out`=1, `busy`=0, `fifo_empty`=1, `fifo_full`=0, `error`=0 throughout.
2. **Single byte.** Write 0xA5 at edge N. Required:
   - `serial_out` falls after edge N+1.
   - Line carries 0,1,0,1,0,0,1,0,1,1, each for 10 cycles.
   - `busy` is high for exactly 100 cycles.
   - `fifo_empty` is high again after edge N+1.
3. **Fill/overflow.**
   - Write 0x00..0x10 (17 bytes) on 17 consecutive edges. Required: `fifo_full`=1 after the 17th write, `error`=0.
   - 18th write (0xFF). Required: rejected, `error`=1.
   - Required on the line: 17 contiguous frames 0x00..0x10 with no idle cycle between stop and start, 0xFF never transmitted, and `fifo_empty`=1 and `busy`=0 after 1700 cycles.
4. **Write at full coinciding with pop.** Required: the write is rejected, `error`=1, and the count reads 15.
5. **Reset mid-frame.**
   - Pull `reset_n` low for 1 cycle during data bit 3 of 0x0F with 2 bytes queued. Required: `serial_out`=1 on the next edge, `busy`=0, `fifo_empty`=1.
   - Idle 100 more cycles. Required: no further frames.
6. **Loopback.** Run at defaults (500 MHz, 9600 baud) with `serial_out` driving `uart_rx` `serial_in`. Send 0x00..0x0F. Required: `uart_rx` reports `error`=0, and successive `display_next` pulses show `data_out_msd`=0 and `data_out_lsd`=0..F in order.
7. **Write into an empty FIFO while IDLE.** Sequence:
   - At the edge that empties the FIFO (pop of byte 0x11), write 0x22.
   - During STOP of 0x11, write 0x33.

   Required: `fifo_empty` is low after the 0x22 write, and frames 0x11, 0x22, 0x33 are transmitted in order.
